// File: rtl/cla8_operand_sequencer_if.sv
// Byte-in / result-out bus of the operand sequencer, including the adder-facing side.
// The slave modport is the sequencer; the master modport is its environment (source, adder, sink).
interface cla8_operand_sequencer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_count;

   modport slave (
      input  in_data, in_valid, add_sum, add_cout, res_ready,
      output in_ready, add_a, add_b, res_sum, res_cout, res_valid, res_count
   );

   modport master (
      output in_data, in_valid, add_sum, add_cout, res_ready,
      input  in_ready, add_a, add_b, res_sum, res_cout, res_valid, res_count
   );
endinterface

// File: rtl/cla8_operand_sequencer.sv
// Feeds two serial operand bytes to an external combinational adder, waits for it to
// settle, then captures sum/carry and offers them on a valid/ready result port.
module cla8_operand_sequencer #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   cla8_operand_sequencer_if.slave       bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_B = 2'd1,
      S_SETTLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q;
   logic [WIDTH-1:0] add_a_q, add_b_q, res_sum_q;
   logic             res_cout_q, res_valid_q;
   logic [7:0]       res_count_q;

   logic accept_a, accept_b, settle_done, result_taken;

   assign accept_a     = (state_q == S_IDLE)   && bus.in_valid;
   assign accept_b     = (state_q == S_LOAD_B) && bus.in_valid;
   assign settle_done  = (state_q == S_SETTLE) && (cnt_q == 4'd0);
   assign result_taken = (state_q == S_DONE)   && bus.res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (accept_a)     state_d = S_LOAD_B;
            S_LOAD_B: if (accept_b)     state_d = S_SETTLE;
            S_SETTLE: if (settle_done)  state_d = S_DONE;
            S_DONE:   if (result_taken) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
         endcase
      end
   end

   // in_ready is held low while reset is asserted so every output reads 0 during reset.
   always_comb begin
      bus.in_ready = 1'b0;
      if (!rst && (state_q == S_IDLE || state_q == S_LOAD_B)) bus.in_ready = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_a_q     <= '0;
         add_b_q     <= '0;
         cnt_q       <= '0;
         res_sum_q   <= '0;
         res_cout_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_count_q <= '0;
      end else if (flush) begin
         // Abort drops the operands but keeps the last captured result and the tally.
         add_a_q     <= '0;
         add_b_q     <= '0;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         if (accept_a) add_a_q <= bus.in_data;
         if (accept_b) begin
            add_b_q <= bus.in_data;
            cnt_q   <= CNT_INIT;
         end
         if (state_q == S_SETTLE) begin
            if (cnt_q != 4'd0) begin
               cnt_q <= cnt_q - 4'd1;
            end else begin
               res_sum_q   <= bus.add_sum;
               res_cout_q  <= bus.add_cout;
               res_valid_q <= 1'b1;
               res_count_q <= res_count_q + 8'd1;
            end
         end
         if (result_taken) res_valid_q <= 1'b0;
      end
   end

   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.res_sum   = res_sum_q;
   assign bus.res_cout  = res_cout_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_count = res_count_q;
endmodule

// File: tb/tb_cla8_operand_sequencer.sv
// Directed plus random bench for cla8_operand_sequencer; a behavioural adder sits on the
// adder port and results are predicted as (A+B) with a 9-bit carry, tallied mod 256.
module tb_cla8_operand_sequencer;
   localparam int SETTLE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   exp_count = 0;

   cla8_operand_sequencer_if #(.WIDTH(8)) bus ();

   cla8_operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(SETTLE)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Environment adder: the combinational unit the sequencer drives and samples.
   assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".in_ready"},  {31'd0, bus.in_ready},  32'd0);
      check({tag, ".add_a"},     {24'd0, bus.add_a},     32'd0);
      check({tag, ".add_b"},     {24'd0, bus.add_b},     32'd0);
      check({tag, ".res_sum"},   {24'd0, bus.res_sum},   32'd0);
      check({tag, ".res_cout"},  {31'd0, bus.res_cout},  32'd0);
      check({tag, ".res_valid"}, {31'd0, bus.res_valid}, 32'd0);
      check({tag, ".res_count"}, {24'd0, bus.res_count}, 32'd0);
   endtask

   // One full A/B transaction; hold = number of cycles the consumer stalls after res_valid.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold);
      logic [8:0] expected;
      expected = {1'b0, a} + {1'b0, b};
      bus.res_ready = (hold == 0);
      check("idle.in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = a;
      step();
      check("loadb.in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("add_a", {24'd0, bus.add_a}, {24'd0, a});
      bus.in_data = b;
      step();
      bus.in_valid = 1'b0;
      check("add_b", {24'd0, bus.add_b}, {24'd0, b});
      for (int i = 0; i < SETTLE - 1; i++) begin
         check("settle.res_valid", {31'd0, bus.res_valid}, 32'd0);
         check("settle.in_ready",  {31'd0, bus.in_ready},  32'd0);
         step();
      end
      check("settle.res_valid_pre", {31'd0, bus.res_valid}, 32'd0);
      step();
      exp_count = (exp_count + 1) % 256;
      check("res_valid", {31'd0, bus.res_valid}, 32'd1);
      check("res_sum",   {24'd0, bus.res_sum},   {24'd0, expected[7:0]});
      check("res_cout",  {31'd0, bus.res_cout},  {31'd0, expected[8]});
      check("res_count", {24'd0, bus.res_count}, exp_count[31:0]);
      for (int d = 0; d < hold; d++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'($urandom);
         step();
         check("bp.res_valid", {31'd0, bus.res_valid}, 32'd1);
         check("bp.res_sum",   {24'd0, bus.res_sum},   {24'd0, expected[7:0]});
         check("bp.in_ready",  {31'd0, bus.in_ready},  32'd0);
         check("bp.add_a",     {24'd0, bus.add_a},     {24'd0, a});
      end
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
      step();
      check("drain.res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("drain.in_ready",  {31'd0, bus.in_ready},  32'd1);
      bus.res_ready = 1'b0;
      $display("txn a=%02h b=%02h hold=%0d -> sum=%02h cout=%0d count=%0d",
               a, b, hold, expected[7:0], expected[8], exp_count);
   endtask

   initial begin
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b0;
      #1;
      check_all_zero("reset");
      step();
      step();
      rst = 1'b0;
      #1;
      check("post_reset.in_ready", {31'd0, bus.in_ready}, 32'd1);

      run_txn(8'h0F, 8'h01, 0);
      run_txn(8'hFF, 8'h01, 0);
      run_txn(8'h80, 8'h80, 0);
      run_txn(8'hAA, 8'h55, 0);
      run_txn(8'h3C, 8'hC4, 5);

      // Flush while waiting for B.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h12;
      step();
      flush        = 1'b1;
      bus.in_data  = 8'h34;
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flushB.add_a",     {24'd0, bus.add_a},     32'd0);
      check("flushB.add_b",     {24'd0, bus.add_b},     32'd0);
      check("flushB.res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("flushB.res_count", {24'd0, bus.res_count}, exp_count[31:0]);
      $display("flush in LOAD_B done");

      // Flush while settling; the result must never appear.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h21;
      step();
      bus.in_data  = 8'h43;
      step();
      bus.in_valid = 1'b0;
      flush        = 1'b1;
      step();
      flush = 1'b0;
      check("flushS.add_a", {24'd0, bus.add_a}, 32'd0);
      check("flushS.add_b", {24'd0, bus.add_b}, 32'd0);
      for (int i = 0; i < SETTLE + 2; i++) begin
         check("flushS.res_valid", {31'd0, bus.res_valid}, 32'd0);
         check("flushS.in_ready",  {31'd0, bus.in_ready},  32'd1);
         step();
      end
      check("flushS.res_count", {24'd0, bus.res_count}, exp_count[31:0]);
      $display("flush in SETTLE done");
      run_txn(8'h5A, 8'h5A, 0);

      // Asynchronous reset in the middle of SETTLE.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      step();
      bus.in_data  = 8'h99;
      step();
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      exp_count = 0;
      step();
      rst = 1'b0;
      #1;
      check("post_areset.in_ready", {31'd0, bus.in_ready}, 32'd1);
      $display("async reset in SETTLE done");
      run_txn(8'h01, 8'h02, 0);

      // Random back-to-back traffic until the tally wraps to 0.
      for (int n = 0; n < 255; n++) begin
         run_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
      end
      check("wrap.res_count", {24'd0, bus.res_count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cla8_operand_sequencer.md
Name: cla8_operand_sequencer

Overview:
- Wraps the 8-bit carry-lookahead adder on both sides: its upstream feed and its downstream capture.
- Accepts two operand bytes serially over a valid/ready byte bus and drives them onto the adder's a/b inputs.
- Waits a fixed number of settle cycles for the gate-delay adder to resolve, then registers sum and carry-out and presents them on a valid/ready result port.
- The adder instance is external; this block only drives its inputs and samples its outputs.

Parameters:
- WIDTH, 8, operand/sum width; must match the adder (8).
- SETTLE_CYCLES, 2, clock edges from B acceptance to result capture; legal range 1..15. Requirement: SETTLE_CYCLES × clock period exceeds the adder worst-case delay.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort to IDLE.
- in_data  input  WIDTH  operand byte; first byte is A, second is B.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a byte.
- add_a  output  WIDTH  drives adder input a.
- add_b  output  WIDTH  drives adder input b.
- add_sum  input  WIDTH  adder sum output.
- add_cout  input  1  adder carry-out.
- res_sum  output  WIDTH  registered sum.
- res_cout  output  1  registered carry-out.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_count  output  8  completed-result counter; wraps 255 -> 0.

Behaviour:
- Reset (async, immediate, any state):
  - State goes to IDLE.
  - add_a, add_b, res_sum, res_cout, res_valid, res_count, and the settle counter all go to 0.
  - in_ready=1 once reset deasserts.
- States: IDLE, LOAD_B, SETTLE, DONE. All registered outputs update on rising clk only.
- IDLE: in_ready=1. On in_valid&in_ready: add_a<=in_data, next state LOAD_B.
- LOAD_B: in_ready=1. On in_valid: add_b<=in_data, cnt<=SETTLE_CYCLES-1, next state SETTLE.
- SETTLE: in_ready=0; in_valid is ignored.
  - Each edge with cnt!=0: cnt<=cnt-1.
  - Edge with cnt==0: res_sum<=add_sum, res_cout<=add_cout, res_valid<=1, res_count<=res_count+1, next state DONE.
  - Result latency: exactly SETTLE_CYCLES edges after the B-accepting edge.
- DONE: in_ready=0; res_valid=1, and res_sum/res_cout hold stable.
  - Edge with res_ready=1: res_valid<=0, next state IDLE.
  - Minimum one cycle in DONE; res_ready asserted early has no effect before res_valid=1.
- add_a/add_b hold their values until overwritten. The adder keeps seeing the last operands after DONE.
- flush=1 at an edge, any state:
  - Next state IDLE; res_valid<=0, cnt<=0, add_a<=0, add_b<=0.
  - res_sum, res_cout, res_count keep their values.
  - flush has priority over in_valid and res_ready on the same edge.
- Result arithmetic is entirely the adder's. This block does no arithmetic except cnt decrement and the res_count 8-bit wrap.
- Back-to-back operation: a new A can be accepted on the first edge after the DONE->IDLE transition. There is no overlap with an outstanding result.
- in_data is sampled only when in_valid&in_ready; values at other times are don't-care.

Test Plan:
- After reset: send A=0x0F, B=0x01, SETTLE_CYCLES=2, res_ready=1. Expected: res_valid rises 2 edges after B accept; res_sum=0x10, res_cout=0, res_count=1; return to IDLE the edge after.
- Carry: A=0xFF, B=0x01. Expected: res_sum=0x00, res_cout=1. Then A=0x80, B=0x80 gives res_sum=0x00, res_cout=1. Then A=0xAA, B=0x55 gives 0xFF, cout=0.
- Backpressure: res_ready=0 for 5 cycles after res_valid. Expected: res_valid/res_sum stable, in_ready=0, in_valid pulses ignored. res_ready=1 clears res_valid next edge.
- flush mid-operation: flush asserted in LOAD_B and again in SETTLE. Expected: IDLE, add_a=add_b=0, res_valid stays 0, res_count unchanged. The next A/B pair completes normally.
- Async reset asserted mid-cycle during SETTLE. Expected: all outputs 0 immediately, without waiting for a clk edge; clean operation after release.
- Counter wrap: 256 back-to-back transactions. Expected: res_count returns to 0; a random A,B compared against (A+B) mod 256 and carry-out on every result.
